sync_pkt_fifo: RTL and testbench
================================

// Module: sync_pkt_fifo
// PURPOSE
//  Single-clock, parametrised packet FIFO. Successor to the fixed 9-bit primitive FIFO wrappers.
//  Generic width/depth, programmable thresholds, optional first-word-fall-through (FWFT).
//  Packet commit/abort: words become readable only when the writer commits the frame.
//  Placement: between the MAC RX parser and the frame consumer; di[8] marks the last byte of a frame.
// PARAMETERS
//  DATA_W      9     word width (8 data bits + last flag)
//  DEPTH_LOG2  13    log2 of depth in words (8192)
//  AF_LEVEL    6600  afull_flag asserts when used words >= AF_LEVEL
//  AE_LEVEL    32    aempty_flag asserts when readable words <= AE_LEVEL
//  FWFT        0     0: standard read, 1 cycle latency; 1: head word shown on do while !empty_flag
// PORTS
//  clk          in   1             single clock for both sides
//  rst          in   1             asynchronous, active-high reset
//  di           in   DATA_W        write data
//  we           in   1             write enable; one word per cycle
//  commit       in   1             publish every word written since the last commit/abort
//  abort        in   1             discard every uncommitted word
//  re           in   1             read enable / pop
//  do           out  DATA_W        read data
//  empty_flag   out  1             no committed words available
//  aempty_flag  out  1             readable words <= AE_LEVEL
//  full_flag    out  1             no free storage (counts uncommitted words)
//  afull_flag   out  1             used words >= AF_LEVEL
//  overflow     out  1             1-cycle pulse: the current frame was dropped
//  rd_count     out  DEPTH_LOG2+1  committed, unread words
// BEHAVIOUR
//  - Pointers are DEPTH_LOG2+1 bits with a wrap bit: wr_ptr (speculative), cm_ptr (committed), rd_ptr.
//  - used = wr_ptr-rd_ptr; readable = cm_ptr-rd_ptr; modulo arithmetic, unsigned.
//  - Reset values:
//    - all pointers 0, do=0, empty_flag=1, aempty_flag=1;
//    - full_flag=0, afull_flag=0, overflow=0, rd_count=0, bad_frame=0.
//  - Reset is honoured mid-frame: uncommitted and committed data are both lost.
//  - All flags and rd_count are registered. They reflect pointer state one cycle after the causing edge.
//  - Write: we && !full_flag && !bad_frame stores di at wr_ptr and increments wr_ptr.
//  - we while full_flag:
//    - the word is dropped and bad_frame is set;
//    - further writes in this frame are ignored.
//  - Commit:
//    - commit && !bad_frame sets cm_ptr to wr_ptr, including any word written in the same cycle.
//    - commit with bad_frame is treated as abort, pulses overflow and clears bad_frame.
//  - Abort:
//    - abort sets wr_ptr to cm_ptr and clears bad_frame.
//    - A same-cycle write is discarded.
//    - abort wins over commit.
//  - Read:
//    - re && !empty_flag increments rd_ptr.
//    - re while empty is ignored; rd_ptr and do hold.
//    - FWFT=0: do updates the cycle after re.
//    - FWFT=1: do holds mem[rd_ptr] whenever !empty_flag. The next word is shown 1 cycle after re,
//      using an output register prefetch, so the RAM stays synchronous.
//  - A read and a commit in the same cycle are both applied; rd_count = old + committed - 1.
//  - Write and read in the same cycle at full: the write is still refused, because full_flag is
//    registered. Documented conservative behaviour.
//  - Empty deasserts 1 cycle after commit, never on write alone.
//  - Wrap: the pointer wrap bit distinguishes full (MSBs differ, LSBs equal) from empty.
// STRUCTURE
//  - Package sync_pkt_fifo_pkg holds localparams: PTR_W = DEPTH_LOG2+1, the pointer typedef,
//    and the LAST_BIT index (DATA_W-1).
//  - One sub-module, sync_fifo_ram:
//    - simple dual-port, one write port and one registered read port;
//    - infers block RAM, with no reset on the array.
//  - Top level: pointer/flag control, bad_frame tracking and the FWFT prefetch register
//    (about 200 lines).
// TESTING
//  1. Reset then write 5 words with no commit -> empty_flag stays 1, rd_count=0.
//     Then commit -> empty_flag=0 and rd_count=5 the next cycle.
//  2. Write 3 words, abort, write 0x1AA plus commit -> only 0x1AA is read back; rd_count=1 then 0.
//  3. DEPTH_LOG2=4: fill 16 words, commit -> full_flag=1.
//     A 17th write plus commit -> overflow pulses, rd_count stays 16.
//     Drain 16 -> empty_flag=1.
//  4. FWFT=1: commit 0x101,0x102 -> do=0x101 with no re.
//     Pulse re -> do=0x102 the next cycle; second re -> empty_flag=1.
//  5. Thresholds with AF_LEVEL=12, AE_LEVEL=2:
//     - after 12 uncommitted writes -> afull_flag=1;
//     - after commit and reading down to 2 words -> aempty_flag=1.
//  6. Assert rst mid-frame during simultaneous we/re -> all outputs return to reset values
//     asynchronously, and no stale data appears after release.

Source files
------------

// File: rtl/sync_pkt_fifo_pkg.sv
// Shared defaults and pointer type for the packet FIFO.
// Pointers carry one extra wrap bit above the address so full and empty can be told apart.
package sync_pkt_fifo_pkg;
  localparam int DATA_W_DEF     = 9;
  localparam int DEPTH_LOG2_DEF = 13;
  localparam int AF_LEVEL_DEF   = 6600;
  localparam int AE_LEVEL_DEF   = 32;
  localparam int PTR_W          = DEPTH_LOG2_DEF + 1;
  localparam int LAST_BIT       = DATA_W_DEF - 1;

  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The storage array has no reset so it maps onto block RAM; only the read register is reset.
module sync_fifo_ram #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/sync_pkt_fifo.sv
// Single-clock packet FIFO with commit/abort, registered flags and optional FWFT output.
// The read data port is named dout because "do" is a reserved word in SystemVerilog.
module sync_pkt_fifo
  import sync_pkt_fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int AF_LEVEL   = AF_LEVEL_DEF,
  parameter int AE_LEVEL   = AE_LEVEL_DEF,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     di,
  input  logic                  we,
  input  logic                  commit,
  input  logic                  abort,
  input  logic                  re,
  output logic [DATA_W-1:0]     dout,
  output logic                  empty_flag,
  output logic                  aempty_flag,
  output logic                  full_flag,
  output logic                  afull_flag,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   rd_count
);
  localparam int AW = DEPTH_LOG2;
  typedef logic [AW:0] fptr_t;

  localparam fptr_t AF_P   = fptr_t'(AF_LEVEL);
  localparam fptr_t AE_P   = fptr_t'(AE_LEVEL);
  localparam fptr_t FULL_P = {1'b1, {AW{1'b0}}};

  fptr_t wr_ptr, cm_ptr, rd_ptr;
  fptr_t wr_nxt, cm_nxt, rd_nxt, used_nxt, readable_nxt;
  logic  bad_frame, bad_nxt, bad_eff, drop, wr_ok, rd_ok, ovf_nxt;
  logic  ram_ren;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_q;

  // A dropped word in the same cycle as commit already spoils the frame.
  always_comb begin
    drop    = we && full_flag && !abort;
    bad_eff = bad_frame || drop;
    wr_ok   = we && !full_flag && !bad_frame && !abort;
    rd_ok   = re && !empty_flag;
    rd_nxt  = rd_ptr + {{AW{1'b0}}, rd_ok};
    wr_nxt  = wr_ptr + {{AW{1'b0}}, wr_ok};
    cm_nxt  = cm_ptr;
    bad_nxt = bad_frame;
    ovf_nxt = 1'b0;
    if (abort) begin
      wr_nxt  = cm_ptr;
      bad_nxt = 1'b0;
    end else if (commit) begin
      bad_nxt = 1'b0;
      if (bad_eff) begin
        wr_nxt  = cm_ptr;
        ovf_nxt = 1'b1;
      end else begin
        cm_nxt = wr_nxt;
      end
    end else if (drop) begin
      bad_nxt = 1'b1;
    end
    used_nxt     = wr_nxt - rd_nxt;
    readable_nxt = cm_nxt - rd_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      bad_frame   <= 1'b0;
      empty_flag  <= 1'b1;
      aempty_flag <= 1'b1;
      full_flag   <= 1'b0;
      afull_flag  <= 1'b0;
      overflow    <= 1'b0;
      rd_count    <= '0;
    end else begin
      wr_ptr      <= wr_nxt;
      cm_ptr      <= cm_nxt;
      rd_ptr      <= rd_nxt;
      bad_frame   <= bad_nxt;
      empty_flag  <= (readable_nxt == '0);
      aempty_flag <= (readable_nxt <= AE_P);
      full_flag   <= (used_nxt == FULL_P);
      afull_flag  <= (used_nxt >= AF_P);
      overflow    <= ovf_nxt;
      rd_count    <= readable_nxt;
    end
  end

  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (di),
    .re    (ram_ren),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  if (FWFT) begin : g_fwft
    // Always prefetch the next head; a word written into that very slot this cycle
    // is not yet visible through the RAM, so it is forwarded from di instead.
    logic              byp_valid;
    logic [DATA_W-1:0] byp_data;
    assign ram_ren   = 1'b1;
    assign ram_raddr = rd_nxt[AW-1:0];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byp_valid <= 1'b0;
        byp_data  <= '0;
      end else begin
        byp_valid <= wr_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]);
        byp_data  <= di;
      end
    end
    assign dout = byp_valid ? byp_data : ram_q;
  end else begin : g_std
    assign ram_ren   = rd_ok;
    assign ram_raddr = rd_ptr[AW-1:0];
    assign dout      = ram_q;
  end
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Bench for sync_pkt_fifo: a standard-read and an FWFT instance (depth 16) share stimulus;
// a queue scoreboard holds committed words in the order they must come back out.
module tb_sync_pkt_fifo;
  logic       clk, rst, we, commit, abort, re;
  logic [8:0] di;
  logic [8:0] dout_a, dout_b;
  logic       empty_a, aempty_a, full_a, afull_a, ovf_a;
  logic       empty_b, aempty_b, full_b, afull_b, ovf_b;
  logic [4:0] cnt_a, cnt_b;

  int n_pass = 0;
  int n_total = 0;

  logic [8:0] pend[$];
  logic [8:0] sb[$];
  bit         bad_m;
  bit         rd_v, ovf_exp;
  logic [8:0] rd_exp;

  sync_pkt_fifo #(.DATA_W(9), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .di(di), .we(we), .commit(commit), .abort(abort), .re(re),
    .dout(dout_a), .empty_flag(empty_a), .aempty_flag(aempty_a), .full_flag(full_a),
    .afull_flag(afull_a), .overflow(ovf_a), .rd_count(cnt_a));

  sync_pkt_fifo #(.DATA_W(9), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .di(di), .we(we), .commit(commit), .abort(abort), .re(re),
    .dout(dout_b), .empty_flag(empty_b), .aempty_flag(aempty_b), .full_flag(full_b),
    .afull_flag(afull_b), .overflow(ovf_b), .rd_count(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    pend.delete();
    sb.delete();
    bad_m = 0;
    rd_v = 0;
    ovf_exp = 0;
  endtask

  // One clock of stimulus; the model is updated from the pre-edge state.
  task automatic step(input bit w, input logic [8:0] d, input bit c, input bit a, input bit r);
    bit full_m, spoil;
    full_m  = (sb.size() + pend.size()) == 16;
    rd_v    = 0;
    ovf_exp = 0;
    if (r && sb.size() > 0) begin
      rd_exp = sb.pop_front();
      rd_v = 1;
    end
    spoil = bad_m || (w && full_m && !a);
    if (w && !a && !full_m && !bad_m) pend.push_back(d);
    if (a) begin
      pend.delete();
      bad_m = 0;
    end else if (c) begin
      if (spoil) begin
        pend.delete();
        ovf_exp = 1;
      end else begin
        foreach (pend[i]) sb.push_back(pend[i]);
        pend.delete();
      end
      bad_m = 0;
    end else if (spoil) begin
      bad_m = 1;
    end
    we = w; di = d; commit = c; abort = a; re = r;
    @(posedge clk); #1;
    we = 0; commit = 0; abort = 0; re = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1; we = 0; commit = 0; abort = 0; re = 0; di = '0;
    clear_model();
    #12;
    n_total++; if (empty_a !== 1'b1) $display("FAIL reset_empty got %b want 1", empty_a); else n_pass++;
    n_total++; if (aempty_a !== 1'b1) $display("FAIL reset_aempty got %b want 1", aempty_a); else n_pass++;
    n_total++; if (full_a !== 1'b0) $display("FAIL reset_full got %b want 0", full_a); else n_pass++;
    n_total++; if (afull_a !== 1'b0) $display("FAIL reset_afull got %b want 0", afull_a); else n_pass++;
    n_total++; if (ovf_a !== 1'b0) $display("FAIL reset_overflow got %b want 0", ovf_a); else n_pass++;
    n_total++; if (cnt_a !== 5'd0) $display("FAIL reset_rd_count got %0d want 0", cnt_a); else n_pass++;
    n_total++; if (dout_a !== 9'h000) $display("FAIL reset_dout_std got %h want 000", dout_a); else n_pass++;
    n_total++; if (dout_b !== 9'h000) $display("FAIL reset_dout_fwft got %h want 000", dout_b); else n_pass++;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_commit();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 9'(9'h010 + i), 0, 0, 0);
      n_total++; if (empty_a !== 1'b1) $display("FAIL uncommitted_empty got %b want 1", empty_a); else n_pass++;
    end
    n_total++; if (cnt_a !== 5'd0) $display("FAIL uncommitted_rd_count got %0d want 0", cnt_a); else n_pass++;
    step(0, '0, 1, 0, 0);
    n_total++; if (empty_a !== 1'b0) $display("FAIL commit_empty got %b want 0", empty_a); else n_pass++;
    n_total++; if (cnt_a !== 5'(sb.size())) $display("FAIL commit_rd_count got %0d want %0d", cnt_a, sb.size()); else n_pass++;
    while (sb.size() > 0) begin
      step(0, '0, 0, 0, 1);
      n_total++; if (dout_a !== rd_exp) $display("FAIL commit_data got %h want %h", dout_a, rd_exp); else n_pass++;
    end
    n_total++; if (empty_a !== 1'b1) $display("FAIL commit_drain_empty got %b want 1", empty_a); else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 9'(9'h050 + i), 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(1, 9'h1AA, 1, 0, 0);
    n_total++; if (cnt_a !== 5'd1) $display("FAIL abort_rd_count got %0d want 1", cnt_a); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_total++; if (!rd_v || dout_a !== 9'h1AA) $display("FAIL abort_data got %h want 1aa", dout_a); else n_pass++;
    n_total++; if (cnt_a !== 5'd0) $display("FAIL abort_rd_count_after got %0d want 0", cnt_a); else n_pass++;
    n_total++; if (empty_a !== 1'b1) $display("FAIL abort_empty got %b want 1", empty_a); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 9'(9'h100 + i * 3), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    n_total++; if (full_a !== 1'b1) $display("FAIL full_flag got %b want 1", full_a); else n_pass++;
    n_total++; if (cnt_a !== 5'd16) $display("FAIL full_rd_count got %0d want 16", cnt_a); else n_pass++;
    step(1, 9'h0EE, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    n_total++; if (ovf_a !== ovf_exp || ovf_exp !== 1'b1) $display("FAIL overflow_pulse got %b want 1", ovf_a); else n_pass++;
    n_total++; if (cnt_a !== 5'd16) $display("FAIL overflow_rd_count got %0d want 16", cnt_a); else n_pass++;
    step(0, '0, 0, 0, 0);
    n_total++; if (ovf_a !== 1'b0) $display("FAIL overflow_one_cycle got %b want 0", ovf_a); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 0, 0, 1);
      n_total++; if (!rd_v || dout_a !== rd_exp) $display("FAIL full_drain_data got %h want %h", dout_a, rd_exp); else n_pass++;
    end
    n_total++; if (empty_a !== 1'b1) $display("FAIL full_drain_empty got %b want 1", empty_a); else n_pass++;
    n_total++; if (full_a !== 1'b0) $display("FAIL full_drain_full got %b want 0", full_a); else n_pass++;
  endtask

  task automatic test_fwft();
    do_reset();
    step(1, 9'h101, 0, 0, 0);
    step(1, 9'h102, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    n_total++; if (dout_b !== sb[0]) $display("FAIL fwft_head got %h want %h", dout_b, sb[0]); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_total++; if (dout_b !== sb[0]) $display("FAIL fwft_next got %h want %h", dout_b, sb[0]); else n_pass++;
    n_total++; if (empty_b !== 1'b0) $display("FAIL fwft_not_empty got %b want 0", empty_b); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_total++; if (empty_b !== 1'b1) $display("FAIL fwft_empty got %b want 1", empty_b); else n_pass++;
    step(1, 9'h155, 1, 0, 0);
    n_total++; if (empty_b !== 1'b0 || dout_b !== 9'h155) $display("FAIL fwft_bypass got %h empty %b want 155 empty 0", dout_b, empty_b); else n_pass++;
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_thresholds();
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 9'(i), 0, 0, 0);
    n_total++; if (afull_a !== 1'b0) $display("FAIL afull_below got %b want 0", afull_a); else n_pass++;
    step(1, 9'h00B, 0, 0, 0);
    n_total++; if (afull_a !== 1'b1) $display("FAIL afull_at got %b want 1", afull_a); else n_pass++;
    step(0, '0, 1, 0, 0);
    n_total++; if (aempty_a !== 1'b0) $display("FAIL aempty_high got %b want 0", aempty_a); else n_pass++;
    for (int i = 0; i < 9; i++) step(0, '0, 0, 0, 1);
    n_total++; if (aempty_a !== 1'b0 || cnt_a !== 5'd3) $display("FAIL aempty_three got %b cnt %0d want 0 cnt 3", aempty_a, cnt_a); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_total++; if (aempty_a !== 1'b1 || cnt_a !== 5'd2) $display("FAIL aempty_two got %b cnt %0d want 1 cnt 2", aempty_a, cnt_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 9'(9'h0C0 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, 9'h0C4, 1, 0, 1);
    n_total++; if (cnt_a !== 5'd4) $display("FAIL commit_read_count got %0d want 4", cnt_a); else n_pass++;
    n_total++; if (dout_a !== rd_exp) $display("FAIL commit_read_data got %h want %h", dout_a, rd_exp); else n_pass++;
    for (int k = 0; k < 300; k++) begin
      bit w, c, a, r;
      w = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 1) == 1);
      step(w, 9'($urandom), c, a, r);
      if (rd_v) begin
        n_total++; if (dout_a !== rd_exp) $display("FAIL rand_data got %h want %h", dout_a, rd_exp); else n_pass++;
      end
      n_total++; if (cnt_a !== 5'(sb.size())) $display("FAIL rand_rd_count got %0d want %0d", cnt_a, sb.size()); else n_pass++;
      n_total++; if (empty_a !== (sb.size() == 0)) $display("FAIL rand_empty got %b want %b", empty_a, sb.size() == 0); else n_pass++;
      n_total++; if (ovf_a !== ovf_exp) $display("FAIL rand_overflow got %b want %b", ovf_a, ovf_exp); else n_pass++;
      if (sb.size() > 0) begin
        n_total++; if (dout_b !== sb[0]) $display("FAIL rand_fwft_head got %h want %h", dout_b, sb[0]); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 9'(9'h070 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, 9'h077, 0, 0, 0);
    we = 1; re = 1; di = 9'h078;
    @(posedge clk);
    #2 rst = 1;
    #1;
    n_total++; if (empty_a !== 1'b1 || empty_b !== 1'b1) $display("FAIL async_empty got %b/%b want 1/1", empty_a, empty_b); else n_pass++;
    n_total++; if (cnt_a !== 5'd0) $display("FAIL async_rd_count got %0d want 0", cnt_a); else n_pass++;
    n_total++; if (dout_a !== 9'h000 || dout_b !== 9'h000) $display("FAIL async_dout got %h/%h want 000/000", dout_a, dout_b); else n_pass++;
    n_total++; if (full_a !== 1'b0 || afull_a !== 1'b0 || ovf_a !== 1'b0 || aempty_a !== 1'b1) $display("FAIL async_flags got f%b af%b o%b ae%b want f0 af0 o0 ae1", full_a, afull_a, ovf_a, aempty_a); else n_pass++;
    we = 0; re = 0;
    #1 rst = 0;
    clear_model();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    n_total++; if (empty_a !== 1'b1 || cnt_a !== 5'd0) $display("FAIL post_reset_state got empty %b cnt %0d want 1 0", empty_a, cnt_a); else n_pass++;
    n_total++; if (dout_a !== 9'h000) $display("FAIL post_reset_dout got %h want 000", dout_a); else n_pass++;
    step(1, 9'h0AB, 1, 0, 0);
    n_total++; if (dout_b !== 9'h0AB || cnt_a !== 5'd1) $display("FAIL post_reset_fwft got %h cnt %0d want 0ab 1", dout_b, cnt_a); else n_pass++;
    step(0, '0, 0, 0, 1);
    n_total++; if (!rd_v || dout_a !== 9'h0AB) $display("FAIL post_reset_data got %h want 0ab", dout_a); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_abort();
    test_full();
    test_fwft();
    test_thresholds();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
